// File: rtl/bus_arbiter_seq.sv
// Serial shared-bus arbiter: picks one of 16 requesters (round-robin or fixed priority),
// then shifts a start bit plus a 76-bit frame out on bus_show, followed by an idle gap.
module bus_arbiter_seq #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic [1:0]  mod,
  input  logic [63:0] tx_data,
  input  logic [3:0]  tx_addr,
  input  logic [3:0]  tx_crc,
  output logic [15:0] grant,
  output logic [3:0]  cur_sender,
  output logic        bus_show,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LATCH, START, SHIFT, GAP} state_t;

  localparam logic [6:0] GAP_LAST = 7'(GAP_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  ptr;
  logic [75:0] shreg;
  logic [6:0]  cnt;

  logic        rr_hit;
  logic [3:0]  rr_win, fp_win, win, idx;
  logic        arb_go;

  // Round-robin scans upward from ptr with natural 4-bit wrap; fixed priority takes lowest index.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = ptr;
    idx    = '0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!rr_hit && req[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx;
      end
    end
    fp_win = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) fp_win = 4'(i);
    end
  end

  assign arb_go = (state == IDLE) && ((mod == 2'd1) || (mod == 2'd2)) && (req != 16'h0);
  assign win    = (mod == 2'd1) ? rr_win : fp_win;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_go) next_state = LATCH;
      LATCH:   next_state = START;
      START:   next_state = SHIFT;
      SHIFT:   if (cnt == 7'd0) next_state = GAP;
      GAP:     if (cnt == 7'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cnt is reused: bit index during SHIFT, remaining gap cycles during GAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      cur_sender <= '0;
      shreg      <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            cur_sender <= win;
            if (mod == 2'd1) ptr <= win + 4'd1;
          end
        end
        LATCH: shreg <= {cur_sender, tx_addr, tx_data, tx_crc};
        START: cnt <= 7'd75;
        SHIFT: cnt <= (cnt == 7'd0) ? GAP_LAST : cnt - 7'd1;
        GAP:   if (cnt != 7'd0) cnt <= cnt - 7'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    grant    = '0;
    bus_show = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      LATCH: grant = 16'(1) << cur_sender;
      START: begin
        grant    = 16'(1) << cur_sender;
        bus_show = 1'b1;
      end
      SHIFT: begin
        grant    = 16'(1) << cur_sender;
        bus_show = shreg[cnt];
      end
      GAP:     done = (cnt == GAP_LAST);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_seq.sv
// Directed bench for bus_arbiter_seq: stimulus queues expected frames, a cycle monitor
// follows each grant through start bit, 76 frame bits and the done pulse.
module tb_bus_arbiter_seq;

  localparam int GAP = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [1:0]  mod;
  logic [63:0] tx_data;
  logic [3:0]  tx_addr;
  logic [3:0]  tx_crc;
  logic [15:0] grant;
  logic [3:0]  cur_sender;
  logic        bus_show, busy, done;

  bus_arbiter_seq #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .req(req), .mod(mod),
    .tx_data(tx_data), .tx_addr(tx_addr), .tx_crc(tx_crc),
    .grant(grant), .cur_sender(cur_sender), .bus_show(bus_show),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  sender;
    logic [75:0] frame;
    bit          b2b;
    bit          abort;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int    cyc = 0;
  int    last_done = 0;
  int    mst = 0;
  int    nbits = 0;
  exp_t  cur;
  logic [75:0] got;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (mst != 0) chk("abort_expected", 76'(cur.abort), 76'd1);
      mst = 0;
    end else begin
      case (mst)
        0: begin
          if (done) chk("unexpected_done", 76'(done), 76'd0);
          if (grant != 16'h0) begin
            if (q.size() == 0) begin
              chk("unexpected_grant", 76'(grant), 76'd0);
            end else begin
              cur = q.pop_front();
              pops++;
              chk("grant_onehot", 76'(grant), 76'(16'(1) << cur.sender));
              chk("cur_sender", 76'(cur_sender), 76'(cur.sender));
              chk("latch_bus_low", 76'(bus_show), 76'd0);
              if (cur.b2b) chk("next_grant_spacing", 76'(cyc - last_done), 76'(GAP + 1));
              mst = 1;
            end
          end
        end
        1: begin
          chk("start_bit", 76'(bus_show), 76'd1);
          nbits = 0;
          got = '0;
          mst = 2;
        end
        2: begin
          got[75 - nbits] = bus_show;
          if (grant != (16'(1) << cur.sender)) chk("grant_hold", 76'(grant), 76'(16'(1) << cur.sender));
          nbits++;
          if (nbits == 76) begin
            chk("frame_bits", got, cur.frame);
            mst = 3;
          end
        end
        default: begin
          chk("done_pulse", 76'(done), 76'd1);
          chk("gap_grant_zero", 76'(grant), 76'd0);
          chk("gap_bus_low", 76'(bus_show), 76'd0);
          chk("abort_flag", 76'(cur.abort), 76'd0);
          last_done = cyc;
          mst = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] s, input bit b2b, input bit abort);
    exp_t e;
    e.sender = s;
    e.frame  = {s, tx_addr, tx_data, tx_crc};
    e.b2b    = b2b;
    e.abort  = abort;
    q.push_back(e);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pops < target && n < 3000) begin
      tick(1);
      n++;
    end
    if (pops < target) chk("timeout_grant", 76'(pops), 76'(target));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || mst != 0 || busy) && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) chk("timeout_idle", 76'(q.size()), 76'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; mod = 2'd0;
    tx_data = 64'h1; tx_addr = 4'h2; tx_crc = 4'h1;
    tick(2);
    @(negedge clock);
    chk("rst_grant", 76'(grant), 76'd0);
    chk("rst_sender", 76'(cur_sender), 76'd0);
    chk("rst_bus", 76'(bus_show), 76'd0);
    chk("rst_busy", 76'(busy), 76'd0);
    chk("rst_done", 76'(done), 76'd0);
    tick(1);
    reset = 1'b0;

    // Hold mode ignores requests, then round-robin from ptr 0 picks node 4.
    mod = 2'd0; req = 16'h00F0;
    for (int i = 0; i < 3; i++) begin
      tick(5);
      @(negedge clock);
      chk("hold_grant", 76'(grant), 76'd0);
      chk("hold_busy", 76'(busy), 76'd0);
    end
    tick(1);
    mod = 2'd1;
    push(4'd4, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("hold_switch_grant", 76'(grant), 76'h0010);
    tick(1);
    req = '0;
    wait_idle();
    chk("sender_retained", 76'(cur_sender), 76'd4);

    // Single request, then mid-frame tx_data change and req drop.
    req = 16'h0001;
    push(4'd0, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("single_grant", 76'(grant), 76'h0001);
    tick(12);
    tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
    req = '0;
    wait_idle();

    // Round-robin fairness from ptr 0 with all requesting.
    do_reset();
    tx_addr = 4'h5; tx_data = 64'hDEAD_BEEF_0123_4567; tx_crc = 4'hA;
    for (int i = 0; i < 17; i++) push(4'(i), (i != 0), 1'b0);
    mod = 2'd1; req = 16'hFFFF;
    wait_pops(pops + 17);
    req = '0;
    wait_idle();

    // Wrap: after node 15, ptr returns to 0.
    req = 16'h8000;
    push(4'd15, 1'b0, 1'b0);
    wait_pops(pops + 1);
    req = 16'h8001;
    push(4'd0, 1'b1, 1'b0);
    push(4'd15, 1'b1, 1'b0);
    wait_pops(pops + 2);
    req = '0;
    wait_idle();

    // Fixed priority, then mode change mid-frame to hold.
    mod = 2'd2; req = 16'h8006;
    push(4'd1, 1'b0, 1'b0);
    push(4'd1, 1'b1, 1'b0);
    push(4'd1, 1'b1, 1'b0);
    wait_pops(pops + 3);
    mod = 2'd0;
    wait_idle();
    tick(20);
    @(negedge clock);
    chk("hold_after_fixed", 76'(busy), 76'd0);
    tick(1);
    // Fixed priority must not have moved ptr (still 0).
    mod = 2'd1; req = 16'hFFFF;
    push(4'd0, 1'b0, 1'b0);
    wait_pops(pops + 1);
    req = '0;
    wait_idle();

    // Reset mid-frame aborts without done.
    req = 16'h0004;
    push(4'd2, 1'b0, 1'b1);
    wait_pops(pops + 1);
    req = '0;
    tick(31);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_grant", 76'(grant), 76'd0);
    chk("abort_sender", 76'(cur_sender), 76'd0);
    chk("abort_bus", 76'(bus_show), 76'd0);
    chk("abort_busy", 76'(busy), 76'd0);
    chk("abort_done", 76'(done), 76'd0);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(20);
      @(negedge clock);
      chk("post_abort_done", 76'(done), 76'd0);
    end
    chk("queue_empty", 76'(q.size()), 76'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_seq.md
BUS_ARBITER_SEQ -- requirements
Module: bus_arbiter_seq

Interface
REQ-001 SHALL have parameter: GAP_CYCLES, 2, idle bus cycles after each frame (legal 1..15).
REQ-002 SHALL have port: clock  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  16  per-node transmit request; bit i = node i.
REQ-005 SHALL have port: mod  input  2  arbitration mode: 0 hold, 1 round-robin, 2 fixed priority, 3 treated as 0.
REQ-006 SHALL have port: tx_data  input  64  payload of granted node (external mux driven by grant).
REQ-007 SHALL have port: tx_addr  input  4  receiver address of granted node.
REQ-008 SHALL have port: tx_crc  input  4  CRC of granted node.
REQ-009 SHALL have port: grant  output  16  one-hot grant, at most one bit set.
REQ-010 SHALL have port: cur_sender  output  4  index of granted node.
REQ-011 SHALL have port: bus_show  output  1  serial shared bus line.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement states IDLE, LATCH, START, SHIFT, GAP.
REQ-015 IDLE: SHALL arbitrate each cycle when mod is 1 or 2 and req != 0; winner registered, next state LATCH; otherwise stay IDLE.
REQ-016 Round-robin (mod=1): SHALL pick first set req bit searching upward from pointer ptr with wrap 15->0; on grant ptr <= winner+1 mod 16.
REQ-017 Fixed priority (mod=2): SHALL pick lowest set req index; ptr unchanged.
REQ-018 mod 0 or 3 in IDLE: SHALL issue no grant, regardless of req.
REQ-019 LATCH (1 cycle): grant[winner]=1, cur_sender=winner; SHALL capture frame {winner[3:0], tx_addr, tx_data, tx_crc} (76 bits) into shift register at end of cycle.
REQ-020 START (1 cycle): bus_show=1 (start bit).
REQ-021 SHIFT (76 cycles): bus_show SHALL emit frame MSB first (sender addr bit3 first, CRC bit0 last), 7-bit counter 75 down to 0.
REQ-022 grant and cur_sender SHALL hold from LATCH through last SHIFT cycle; grant=0 in GAP and IDLE.
REQ-023 GAP: bus_show=0 for GAP_CYCLES cycles; done=1 in first GAP cycle only; then IDLE.
REQ-024 Latency: req seen in IDLE cycle N -> grant at N+1, start bit at N+2, last data bit at N+78, done at N+79, earliest next grant at N+79+GAP_CYCLES+1.
REQ-025 Requests SHALL be ignored outside IDLE; deasserting req mid-frame SHALL NOT abort the frame.
REQ-026 mod changes outside IDLE SHALL NOT affect the current frame; take effect at next IDLE arbitration.
REQ-027 Inputs tx_* SHALL be sampled only in LATCH; later changes SHALL NOT alter the frame.
REQ-028 bus_show SHALL be 0 in IDLE, LATCH and GAP.
REQ-029 cur_sender SHALL retain last winner in GAP/IDLE.

Reset
REQ-030 reset=1 SHALL, at next edge, force IDLE, ptr=0, grant=0, cur_sender=0, bus_show=0, busy=0, done=0, shift register and counters 0.
REQ-031 reset mid-frame SHALL abort the frame without done pulse; reset has priority over all other inputs.

Verification
REQ-032 Single request: mod=1, req=16'h0001, tx_addr=2, tx_data=1, tx_crc=1 -> grant=16'h0001 one cycle later, bus_show = 1 then 0000,0010,63x0,1,0001, done pulse at N+79.
REQ-033 Round-robin fairness: mod=1, req=16'hFFFF held -> grants in order node 0,1,2,...,15,0 with no repeats.
REQ-034 Fixed priority: mod=2, req=16'h8006 held -> node 1 granted every frame; nodes 2 and 15 never.
REQ-035 Hold mode: mod=0, req=16'h00F0 -> grant=0, busy=0 indefinitely; switch to mod=1 -> node 4 granted next cycle.
REQ-036 Mid-frame: change tx_data and drop req during SHIFT -> frame bits unchanged, done still pulses; reset asserted at SHIFT bit 30 -> all outputs 0 next cycle, no done.
REQ-037 Wrap: mod=1, ptr after granting node 15 -> req=16'h8001 grants node 0 before node 15.
